// File: rtl/alu_exec_unit.sv
// ALU execution stage: single-cycle ALU ops plus iterative MUL/DIV, writing the accumulator back.
// Build option: define ALU_MULDIV_EN to enable opcodes 9/10 (shift-add MUL, restoring DIV).
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_acc,
  input  logic [WIDTH-1:0] operand_reg,
  output logic [WIDTH-1:0] data_in_acc_alu,
  output logic             signal_save_after_alu,
  output logic             busy,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] exec_res;
  logic             exec_carry, exec_err;

`ifdef ALU_MULDIV_EN
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mul_acc_nxt, div_r_nxt, div_q_nxt, iter_res;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge, is_mul, div_by_zero, start_muldiv;

  assign start_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_mul       = (op_q == OP_MUL);
  assign div_by_zero  = (op_q == OP_DIV) && (b_q == '0);

  // MUL: acc accumulates a_q (shifted left) for each set bit of b_q (shifted right).
  // DIV: acc is the partial remainder, a_q shifts the dividend out and the quotient in.
  always_comb begin
    mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    div_sh      = {acc_q, a_q[WIDTH-1]};
    div_diff    = div_sh - {1'b0, b_q};
    div_ge      = (div_sh >= {1'b0, b_q});
    div_r_nxt   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_q_nxt   = {a_q[WIDTH-2:0], div_ge};
    iter_res    = is_mul ? mul_acc_nxt : div_q_nxt;
  end
`endif

  always_comb begin
    exec_res   = a_q;
    exec_carry = 1'b0;
    exec_err   = 1'b0;
    case (op_q)
      OP_ADD:  {exec_carry, exec_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  {exec_carry, exec_res} = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_NOT:  exec_res = ~a_q;
      OP_SHL:  begin
        exec_res   = {a_q[WIDTH-2:0], 1'b0};
        exec_carry = a_q[WIDTH-1];
      end
      OP_SHR:  begin
        exec_res   = {1'b0, a_q[WIDTH-1:1]};
        exec_carry = a_q[0];
      end
      OP_PASS: exec_res = b_q;
      // Illegal opcodes return A so the accumulator is left unchanged.
      default: exec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef ALU_MULDIV_EN
          state_nxt = start_muldiv ? ITER : EXEC;
`else
          state_nxt = EXEC;
`endif
        end
      end
      EXEC: state_nxt = DONE;
`ifdef ALU_MULDIV_EN
      ITER: state_nxt = (div_by_zero || cnt_q == CNT_W'(1)) ? DONE : ITER;
`else
      ITER: state_nxt = IDLE;
`endif
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy                  = (state != IDLE);
    signal_save_after_alu = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q            <= '0;
      a_q             <= '0;
      b_q             <= '0;
      data_in_acc_alu <= '0;
      flag_zero       <= 1'b0;
      flag_neg        <= 1'b0;
      flag_carry      <= 1'b0;
      flag_err        <= 1'b0;
`ifdef ALU_MULDIV_EN
      acc_q           <= '0;
      cnt_q           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= opcode;
            a_q  <= operand_acc;
            b_q  <= operand_reg;
`ifdef ALU_MULDIV_EN
            acc_q <= '0;
            cnt_q <= CNT_W'(WIDTH);
`endif
          end
        end
        EXEC: begin
          data_in_acc_alu <= exec_res;
          flag_zero       <= (exec_res == '0);
          flag_neg        <= exec_res[WIDTH-1];
          flag_carry      <= exec_carry;
          flag_err        <= exec_err;
        end
`ifdef ALU_MULDIV_EN
        ITER: begin
          if (div_by_zero) begin
            data_in_acc_alu <= '1;
            flag_zero       <= 1'b0;
            flag_neg        <= 1'b1;
            flag_carry      <= 1'b0;
            flag_err        <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (is_mul) begin
              acc_q <= mul_acc_nxt;
              a_q   <= {a_q[WIDTH-2:0], 1'b0};
              b_q   <= {1'b0, b_q[WIDTH-1:1]};
            end else begin
              acc_q <= div_r_nxt;
              a_q   <= div_q_nxt;
            end
            if (cnt_q == CNT_W'(1)) begin
              data_in_acc_alu <= iter_res;
              flag_zero       <= (iter_res == '0);
              flag_neg        <= iter_res[WIDTH-1];
              flag_carry      <= 1'b0;
              flag_err        <= 1'b0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: results, flags and strobe timing against a behavioural model.
// Expectations for opcodes 9/10 follow the ALU_MULDIV_EN build option.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] operand_acc, operand_reg;
  logic [15:0] data_in_acc_alu;
  logic        signal_save_after_alu, busy;
  logic        flag_zero, flag_neg, flag_carry, flag_err;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int unsigned lat;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned busy_bad = 0;

  alu_exec_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .opcode                (opcode),
    .operand_acc           (operand_acc),
    .operand_reg           (operand_reg),
    .data_in_acc_alu       (data_in_acc_alu),
    .signal_save_after_alu (signal_save_after_alu),
    .busy                  (busy),
    .flag_zero             (flag_zero),
    .flag_neg              (flag_neg),
    .flag_carry            (flag_carry),
    .flag_err              (flag_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] w;
    logic [31:0] p;
    logic [15:0] r;
    logic        c, er;
    c  = 1'b0;
    er = 1'b0;
    e.lat = 2;
    e.cyc = 0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a << 1; c = a[15]; end
      4'd7: begin r = a >> 1; c = a[0]; end
      4'd8: r = b;
`ifdef ALU_MULDIV_EN
      4'd9: begin p = a * b; r = p[15:0]; e.lat = 17; end
      4'd10: begin
        if (b == 16'h0) begin r = 16'hFFFF; er = 1'b1; end
        else begin r = a / b; e.lat = 17; end
      end
`endif
      default: begin r = a; er = 1'b1; end
    endcase
    e.res = r;
    e.flg = {(r == 16'h0), r[15], c, er};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && signal_save_after_alu) begin
      if (sb.size() == 0) begin
        check("spurious_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {16'h0, data_in_acc_alu}, {16'h0, e.res});
        check("flags_znce", {28'h0, flag_zero, flag_neg, flag_carry, flag_err}, {28'h0, e.flg});
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  // Drives one op, keeps busy-coverage counts, optionally pulses start while busy.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit pulse);
    exp_t        e;
    int unsigned c0, n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_wait", 32'd1, 32'd0);
    start       = 1'b1;
    opcode      = op;
    operand_acc = a;
    operand_reg = b;
    e = model(op, a, b);
    @(posedge clk);
    #1;
    c0 = cyc;
    e.cyc = c0 + e.lat - 1;
    sb.push_back(e);
    @(negedge clk);
    start       = 1'b0;
    opcode      = 4'($urandom);
    operand_acc = 16'($urandom);
    operand_reg = 16'($urandom);
    while (cyc + 1 < c0 + e.lat) begin
      if (!busy) busy_bad++;
      start = pulse;
      @(negedge clk);
      start = 1'b0;
    end
    if (!busy) busy_bad++;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        e;
    int unsigned c0, n;
    logic [3:0]  op;
    logic [15:0] b;

    rst = 1'b0;
    start = 1'b0;
    opcode = 4'h0;
    operand_acc = 16'h0;
    operand_reg = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {11'h0, data_in_acc_alu, signal_save_after_alu, busy, flag_zero, flag_neg, flag_carry, flag_err}, 32'h0);
    rst = 1'b1;

    run_op(4'd0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(4'd1, 16'h0003, 16'h0005, 1'b0);
    run_op(4'd7, 16'h8001, 16'h0000, 1'b0);
    run_op(4'd6, 16'h8001, 16'h0000, 1'b0);
    run_op(4'd9, 16'h0123, 16'h0045, 1'b1);
    run_op(4'd10, 16'h0064, 16'h0007, 1'b1);
    run_op(4'd10, 16'h1234, 16'h0000, 1'b0);
    run_op(4'd12, 16'h1234, 16'h5555, 1'b0);
    run_op(4'd9, 16'h1234, 16'h0002, 1'b0);
    run_op(4'd8, 16'h0000, 16'hA5A5, 1'b0);
    run_op(4'd5, 16'h00FF, 16'h0000, 1'b1);
    run_op(4'd4, 16'h5A5A, 16'h5A5A, 1'b0);
    run_op(4'd2, 16'hF0F0, 16'h3C3C, 1'b0);
    run_op(4'd3, 16'hF000, 16'h000F, 1'b0);

    // Reset while an op (MUL) is in flight: aborted, no strobe, outputs cleared.
    @(negedge clk);
    start = 1'b1;
    opcode = 4'd9;
    operand_acc = 16'h0123;
    operand_reg = 16'h0045;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_outputs",
          {11'h0, data_in_acc_alu, signal_save_after_alu, busy, flag_zero, flag_neg, flag_carry, flag_err}, 32'h0);
    rst = 1'b1;
    run_op(4'd0, 16'h1000, 16'h0234, 1'b0);

    // Held start: second op captured on the IDLE cycle after DONE.
    @(negedge clk);
    start = 1'b1;
    opcode = 4'd0;
    operand_acc = 16'h1111;
    operand_reg = 16'h2222;
    e = model(4'd0, 16'h1111, 16'h2222);
    @(posedge clk);
    #1;
    c0 = cyc;
    e.cyc = c0 + 1;
    sb.push_back(e);
    e.cyc = c0 + 4;
    sb.push_back(e);
    repeat (4) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      b  = 16'($urandom);
      if (op == 4'd10 && (i % 3) == 0) b = 16'($urandom_range(0, 3));
      run_op(op, 16'($urandom), b, (i % 2) == 1);
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("busy_during_op", busy_bad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execution stage directly downstream of general_purpose_registers. Consumes the accumulator and the selected X/Y register value, and executes one ALU operation per start request. Single-cycle ops complete in one clock; MUL/DIV run as iterative multi-cycle ops. Returns the result on data_in_acc_alu with a one-cycle signal_save_after_alu pulse, which writes the accumulator back.

Parameters:
WIDTH, 16, operand/result width in bits; must match the register file width.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-low
start  input  1  request; sampled only in IDLE
opcode  input  4  operation select, captured with start
operand_acc  input  WIDTH  A operand, from data_out_accumulator
operand_reg  input  WIDTH  B operand, from data_out (X or Y)
data_in_acc_alu  output  WIDTH  registered result to the accumulator
signal_save_after_alu  output  1  one-cycle write-back strobe
busy  output  1  high from the cycle after start capture until the strobe cycle, inclusive
flag_zero  output  1  result == 0
flag_neg  output  1  result MSB
flag_carry  output  1  carry/borrow out (ADD/SUB/shifts only)
flag_err  output  1  divide-by-zero or illegal opcode

Behaviour:
- Reset (rst low at a rising edge):
  - state = IDLE.
  - All outputs = 0.
  - Internal operand, accumulator and counter registers cleared.
  - Reset mid-operation aborts the operation with no strobe.
- Opcodes:
  - 0 ADD: A+B, carry = bit WIDTH.
  - 1 SUB: A-B, carry = borrow (A<B unsigned).
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT: ~A.
  - 6 SHL: A<<1, carry = A MSB.
  - 7 SHR: logical A>>1, carry = A LSB.
  - 8 PASS: B (load accumulator from register).
  - 9 MUL: low WIDTH bits of unsigned A*B.
  - 10 DIV: unsigned quotient A/B.
  - 11-15 illegal.
- States: IDLE, EXEC, ITER, DONE.
- IDLE:
  - If start=1, capture opcode, A and B.
  - MUL/DIV (when enabled) -> ITER, with the counter loaded with WIDTH.
  - Any other opcode -> EXEC.
- EXEC (1 cycle): compute the result and flags, register them -> DONE.
- ITER:
  - Performs one shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle.
  - The counter decrements each cycle; when the counter reaches 1 the final step is done -> DONE.
  - DIV with B==0 skips iteration: result = all ones, flag_err = 1 -> DONE next cycle.
- DONE (1 cycle):
  - signal_save_after_alu = 1; data_in_acc_alu and the flags are valid.
  - Returns to IDLE.
- Latency from the start-capture edge to the strobe cycle:
  - Single-cycle ops: 2 cycles.
  - MUL/DIV: WIDTH+1 cycles.
  - DIV by zero: 2 cycles.
- busy is high in EXEC, ITER and DONE; low in IDLE.
- start while busy is ignored (not queued); start is level-sampled, so a held start re-triggers on the IDLE cycle after DONE.
- Operands are captured at start; later changes on operand_acc/operand_reg do not affect the result.
- Illegal opcode:
  - Takes the EXEC path with flag_err = 1.
  - Strobe is still issued, with data_in_acc_alu = captured A, so the accumulator is unchanged.
- data_in_acc_alu and the flags hold their last value between operations; they are updated only on entry to DONE.
- flag_zero and flag_neg are always computed from the final result.
- flag_carry = 0 for logic ops, PASS, MUL and DIV.
- flag_err = 0 except for the cases above.
- Arithmetic is modulo 2^WIDTH; MUL overflow is discarded silently.

Optional Feature:
ALU_MULDIV_EN:
- Defined: opcodes 9/10 are legal; the ITER state and the shift-add/shift-subtract datapath are instantiated.
- Undefined: ITER and its datapath are removed. Opcodes 9/10 are treated as illegal: EXEC path, flag_err = 1, result = A, 2-cycle latency.

Test Plan:
- Reset: hold rst=0 for 2 clocks during a MUL in progress -> all outputs 0, state IDLE, no strobe; the next ADD proceeds normally.
- ADD overflow: A=0xFFFF, B=0x0001, op 0 -> strobe 2 cycles after capture with result 0x0000, zero=1, carry=1, neg=0.
- SUB borrow: A=0x0003, B=0x0005, op 1 -> result 0xFFFE, neg=1, carry=1. SHR of 0x8001 -> result 0x4000, carry=1.
- MUL (macro defined): A=0x0123, B=0x0045 -> result 0x4E6F, strobe exactly 17 cycles after capture, busy high throughout; start pulses in between are ignored.
- DIV: A=0x0064, B=0x0007 -> result 0x000E, 17 cycles. B=0 -> result 0xFFFF, err=1, 2 cycles.
- Illegal/undefined macro: op 12 (and op 9 without ALU_MULDIV_EN), A=0x1234 -> strobe with result 0x1234, err=1. Held start -> back-to-back ops separated by one IDLE cycle.
